muxn_stage: RTL and testbench

Parametrised N-channel, WIDTH-bit registered multiplexer stage with valid/ready handshaking. It is the sequential successor to the two-input combinational select mux and is intended for datapath and pipeline merge points such as writeback-source and forwarding merges.
- **Selection:** in MODE 0 the input is picked by an external select; in MODE 1 it is picked by a round-robin arbiter.
- **Registering:** the chosen beat is captured in a one-entry output register, which gives one cycle of latency at full throughput.

---
 rtl/muxn_pkg.sv | 15 +
 rtl/muxn_stage_rr_arbiter.sv | 29 ++
 rtl/muxn_stage.sv | 118 +++++++++++
 tb/tb_muxn_stage.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/muxn_pkg.sv
// Shared types and sizing helpers for the registered N-way mux stage.
package muxn_pkg;

    typedef enum logic {
        MUX_SEL = 1'b0,
        MUX_RR  = 1'b1
    } mux_mode_e;

    localparam int MUX_MIN_N = 2;

    function automatic int sel_width(input int n);
        return (n < MUX_MIN_N) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/muxn_stage_rr_arbiter.sv
// Round-robin search: first requester strictly after ptr, wrapping at N.
module rr_arbiter
    import muxn_pkg::*;
#(
    parameter int N = 4,
    localparam int SELW = sel_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic            grant,
    output logic [SELW-1:0] idx
);

    int c;

    always_comb begin
        grant = 1'b0;
        idx   = '0;
        c     = 0;
        for (int k = 1; k <= N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!grant && req[c]) begin
                grant = 1'b1;
                idx   = SELW'(c);
            end
        end
    end

endmodule

// File: rtl/muxn_stage.sv
// Registered N-channel mux with valid/ready handshake; the channel is picked
// either by an external select or by a round-robin arbiter.
module muxn_stage
    import muxn_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int MODE  = 0,
    localparam int SELW = sel_width(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic [SELW-1:0]    sel,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_ch,
    output logic               sel_err
);

    localparam bit IS_RR = (MODE == int'(MUX_RR));

    logic             load_en;
    logic             m0_ok;
    logic             m0_grant;
    logic             rr_grant;
    logic [SELW-1:0]  rr_idx;
    logic             grant;
    logic [SELW-1:0]  g;
    logic             accept;
    logic [WIDTH-1:0] g_data;

    always_comb begin
        m0_ok    = int'(sel) < N;
        m0_grant = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == SELW'(i) && in_valid[i]) m0_grant = 1'b1;
        end
    end

    assign grant   = IS_RR ? rr_grant : m0_grant;
    assign g       = IS_RR ? rr_idx : sel;
    assign load_en = !out_valid || out_ready;
    // Reset also blocks acceptance so nothing is lost in the reset cycle.
    assign accept  = load_en && !flush && !reset && grant;

    always_comb begin
        in_ready = '0;
        g_data   = '0;
        for (int i = 0; i < N; i++) begin
            if (g == SELW'(i)) begin
                in_ready[i] = accept;
                g_data      = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load_en) begin
            if (grant) begin
                out_valid <= 1'b1;
                out_data  <= g_data;
                out_ch    <= g;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) sel_err <= 1'b0;
        else       sel_err <= !IS_RR && !m0_ok;
    end

    generate
        if (IS_RR) begin : g_rr
            logic [SELW-1:0] ptr;

            // ptr = N-1 gives channel 0 first priority out of reset.
            always_ff @(posedge clk) begin
                if (reset)       ptr <= SELW'(N - 1);
                else if (accept) ptr <= rr_idx;
            end

            rr_arbiter #(.N(N)) u_arb (
                .req   (in_valid),
                .ptr   (ptr),
                .grant (rr_grant),
                .idx   (rr_idx)
            );
        end else begin : g_sel
            assign rr_grant = 1'b0;
            assign rr_idx   = '0;
        end
    endgenerate

`ifndef SYNTHESIS
    a_ready_onehot: assert property (@(posedge clk) $onehot0(in_ready));

    a_stall_stable: assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready && !flush)
        |=> ($stable(out_data) && $stable(out_ch)));

    a_ch_range: assert property (@(posedge clk)
        out_valid |-> (int'(out_ch) < N));
`endif

endmodule

// File: tb/tb_muxn_stage.sv
// Directed checks for muxn_stage in select mode (N=4, N=3) and round-robin mode.
module tb_muxn_stage;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic         a_flush, a_out_valid, a_out_ready, a_sel_err;
    logic [1:0]   a_sel, a_out_ch;
    logic [3:0]   a_in_valid, a_in_ready;
    logic [127:0] a_in_data;
    logic [31:0]  a_out_data;

    logic         b_flush, b_out_valid, b_out_ready, b_sel_err;
    logic [1:0]   b_sel, b_out_ch;
    logic [2:0]   b_in_valid, b_in_ready;
    logic [95:0]  b_in_data;
    logic [31:0]  b_out_data;

    logic         c_flush, c_out_valid, c_out_ready, c_sel_err;
    logic [1:0]   c_sel, c_out_ch;
    logic [3:0]   c_in_valid, c_in_ready;
    logic [127:0] c_in_data;
    logic [31:0]  c_out_data;

    muxn_stage #(.WIDTH(32), .N(4), .MODE(0)) u_a (
        .clk(clk), .reset(reset), .flush(a_flush), .sel(a_sel),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_ch(a_out_ch), .sel_err(a_sel_err)
    );

    muxn_stage #(.WIDTH(32), .N(3), .MODE(0)) u_b (
        .clk(clk), .reset(reset), .flush(b_flush), .sel(b_sel),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_ch(b_out_ch), .sel_err(b_sel_err)
    );

    muxn_stage #(.WIDTH(32), .N(4), .MODE(1)) u_c (
        .clk(clk), .reset(reset), .flush(c_flush), .sel(c_sel),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .out_ch(c_out_ch), .sel_err(c_sel_err)
    );

    typedef struct {
        logic [1:0]  sel;
        logic [3:0]  iv;
        logic        ordy;
        logic        flush;
        logic [3:0]  x_rdy;
        logic        x_ov;
        logic [31:0] x_data;
        logic [1:0]  x_ch;
    } vec_t;

    vec_t tv[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cdat(input int i);
        return 32'hC000_0000 + 32'(i);
    endfunction

    initial begin
        reset = 1'b1;
        a_flush = 0; a_sel = 0; a_in_valid = 0; a_out_ready = 0;
        b_flush = 0; b_sel = 0; b_in_valid = 0; b_out_ready = 0;
        c_flush = 0; c_sel = 0; c_in_valid = 0; c_out_ready = 0;
        a_in_data = {32'h4444_4444, 32'hDEAD_BEEF,
                     32'h2222_2222, 32'h1111_1111};
        b_in_data = {32'hB000_0002, 32'hB000_0001, 32'hB000_0000};
        c_in_data = {cdat(3), cdat(2), cdat(1), cdat(0)};

        tv[0] = '{2'd2, 4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, 32'hDEAD_BEEF, 2'd2};
        tv[1] = '{2'd0, 4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 32'h1111_1111, 2'd0};
        tv[2] = '{2'd1, 4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h1111_1111, 2'd0};
        tv[3] = '{2'd3, 4'b1000, 1'b0, 1'b0, 4'b1000, 1'b1, 32'h4444_4444, 2'd3};
        tv[4] = '{2'd1, 4'b0010, 1'b0, 1'b0, 4'b0000, 1'b1, 32'h4444_4444, 2'd3};
        tv[5] = '{2'd1, 4'b0010, 1'b1, 1'b1, 4'b0000, 1'b0, 32'h4444_4444, 2'd3};
        tv[6] = '{2'd1, 4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 32'h2222_2222, 2'd1};
        tv[7] = '{2'd2, 4'b0110, 1'b1, 1'b0, 4'b0100, 1'b1, 32'hDEAD_BEEF, 2'd2};

        repeat (2) @(posedge clk);
        #1;
        chk("rst a_ov", a_out_valid, 0);
        chk("rst a_data", a_out_data, 0);
        chk("rst a_ch", a_out_ch, 0);
        chk("rst a_err", a_sel_err, 0);
        chk("rst c_ov", c_out_valid, 0);
        chk("rst c_ch", c_out_ch, 0);
        @(negedge clk) reset = 1'b0;

        // MODE 0, N=4 vector table
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a_sel = tv[i].sel; a_in_valid = tv[i].iv;
            a_out_ready = tv[i].ordy; a_flush = tv[i].flush;
            #1 chk($sformatf("a%0d rdy", i), a_in_ready, tv[i].x_rdy);
            @(posedge clk); #1;
            chk($sformatf("a%0d ov", i), a_out_valid, tv[i].x_ov);
            chk($sformatf("a%0d data", i), a_out_data, tv[i].x_data);
            chk($sformatf("a%0d ch", i), a_out_ch, tv[i].x_ch);
            chk($sformatf("a%0d err", i), a_sel_err, 0);
        end
        @(negedge clk);
        a_in_valid = 0; a_flush = 0;

        // MODE 0, N=3 out-of-range select
        b_sel = 2'd3; b_in_valid = 3'b111; b_out_ready = 1;
        #1 chk("b bad rdy", b_in_ready, 0);
        @(posedge clk); #1;
        chk("b bad err", b_sel_err, 1);
        chk("b bad ov", b_out_valid, 0);
        @(negedge clk) b_sel = 2'd0;
        #1 chk("b ok rdy", b_in_ready, 3'b001);
        @(posedge clk); #1;
        chk("b ok err", b_sel_err, 0);
        chk("b ok ov", b_out_valid, 1);
        chk("b ok data", b_out_data, 32'hB000_0000);
        chk("b ok ch", b_out_ch, 0);
        @(negedge clk) b_in_valid = 0;

        // MODE 1 fairness: 0,1,2,3,0,1
        c_in_valid = 4'b1111; c_out_ready = 1; c_sel = 2'd3;
        for (int k = 0; k < 6; k++) begin
            if (k != 0) @(negedge clk);
            #1 chk($sformatf("rr%0d rdy", k), c_in_ready, 4'b0001 << (k % 4));
            @(posedge clk); #1;
            chk($sformatf("rr%0d ch", k), c_out_ch, k % 4);
            chk($sformatf("rr%0d data", k), c_out_data, cdat(k % 4));
            chk($sformatf("rr%0d err", k), c_sel_err, 0);
        end

        // skip over idle channels
        @(negedge clk) c_in_valid = 4'b1010;
        #1 chk("skip rdy3", c_in_ready, 4'b1000);
        @(posedge clk); #1 chk("skip ch3", c_out_ch, 3);
        @(negedge clk);
        #1 chk("skip rdy1", c_in_ready, 4'b0010);
        @(posedge clk); #1 chk("skip ch1", c_out_ch, 1);

        // stall 5 cycles then release with no bubble
        @(negedge clk) c_in_valid = 4'b1111; c_out_ready = 0;
        for (int k = 0; k < 5; k++) begin
            if (k != 0) @(negedge clk);
            #1 chk($sformatf("stall%0d rdy", k), c_in_ready, 0);
            @(posedge clk); #1;
            chk($sformatf("stall%0d ov", k), c_out_valid, 1);
            chk($sformatf("stall%0d ch", k), c_out_ch, 1);
            chk($sformatf("stall%0d data", k), c_out_data, cdat(1));
        end
        @(negedge clk) c_out_ready = 1;
        #1 chk("release rdy", c_in_ready, 4'b0100);
        @(posedge clk); #1;
        chk("release ov", c_out_valid, 1);
        chk("release ch", c_out_ch, 2);

        // flush while stalled; ptr must stay at 2
        @(negedge clk) c_out_ready = 0;
        @(negedge clk) c_flush = 1;
        #1 chk("flush rdy", c_in_ready, 0);
        @(posedge clk); #1 chk("flush ov", c_out_valid, 0);
        @(negedge clk) c_flush = 0; c_out_ready = 1;
        #1 chk("postflush rdy", c_in_ready, 4'b1000);
        @(posedge clk); #1 chk("postflush ch", c_out_ch, 3);
        @(negedge clk);
        #1 chk("pre-rst rdy", c_in_ready, 4'b0001);

        // reset during a stall
        @(negedge clk) c_out_ready = 0; reset = 1;
        #1 chk("rst-stall rdy", c_in_ready, 0);
        @(posedge clk); #1;
        chk("rst-stall ov", c_out_valid, 0);
        chk("rst-stall data", c_out_data, 0);
        chk("rst-stall ch", c_out_ch, 0);
        chk("rst-stall err", c_sel_err, 0);
        @(negedge clk) reset = 0; c_out_ready = 1;
        #1 chk("post-rst rdy", c_in_ready, 4'b0001);
        @(posedge clk); #1;
        chk("post-rst ov", c_out_valid, 1);
        chk("post-rst ch", c_out_ch, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
